// File: rtl/alu_pkg.sv
// Shared constants and helpers for the simple CPU ALU.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_AND  = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_MOVI = 4'd6;
   localparam logic [3:0] OP_MOV  = 4'd7;

   localparam logic [2:0] SH_NONE = 3'b000;
   localparam logic [2:0] SH_LSR  = 3'b001;
   localparam logic [2:0] SH_LSL  = 3'b010;
   localparam logic [2:0] SH_ROR  = 3'b011;
   localparam logic [2:0] SH_ASR  = 3'b100;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Signed overflow from the sign bits of the two operands and the result.
   // For subtraction, pass the inverted sign of the subtrahend.
   function automatic logic add_overflow(input logic a_msb, input logic b_msb,
                                         input logic r_msb);
      return (a_msb == b_msb) && (r_msb != a_msb);
   endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter/rotator applied to operand 2 ahead of the ALU.
// Carry out is the last bit shifted or rotated out; a zero amount or a
// pass-through code forwards carry_in untouched.
module alu_shifter #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] In2,
   input  logic [2:0]       SR_Cont,
   input  logic [4:0]       SR_Bit,
   input  logic             carry_in,
   output logic [WIDTH-1:0] sh_out,
   output logic             sh_carry
);
   import alu_pkg::*;

   logic [4:0] amt_m1;
   logic [5:0] lsl_idx;

   // Select shift/rotate result and the bit that fell off the end.
   always_comb begin
      amt_m1   = SR_Bit - 5'd1;
      lsl_idx  = 6'(WIDTH) - {1'b0, SR_Bit};
      sh_out   = In2;
      sh_carry = carry_in;
      if (SR_Bit != 5'd0) begin
         case (SR_Cont)
            SH_LSR: begin
               sh_out   = In2 >> SR_Bit;
               sh_carry = In2[amt_m1];
            end
            SH_LSL: begin
               sh_out   = In2 << SR_Bit;
               sh_carry = In2[lsl_idx[4:0]];
            end
            SH_ROR: begin
               sh_out   = (In2 >> SR_Bit) | (In2 << lsl_idx);
               sh_carry = In2[amt_m1];
            end
            SH_ASR: begin
               sh_out   = WIDTH'($signed(In2) >>> SR_Bit);
               sh_carry = In2[amt_m1];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/alu_simple.sv
// 32-bit integer ALU: shifted operand 2, arithmetic/logic/move select,
// registered result and optionally updated NZCV flags. One cycle latency.
module alu_simple #(
   parameter int WIDTH     = 32,
   parameter int IMM_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     In1,
   input  logic [WIDTH-1:0]     In2,
   input  logic [IMM_WIDTH-1:0] Immediate,
   input  logic [3:0]           Opcode,
   input  logic [2:0]           SR_Cont,
   input  logic [4:0]           SR_Bit,
   input  logic                 S,
   output logic [WIDTH-1:0]     Out,
   output logic [3:0]           Flags
);
   import alu_pkg::*;

   logic [WIDTH-1:0] sh;
   logic             sh_carry;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] result;
   logic             c_new;
   logic             v_new;
   logic [3:0]       flags_next;
   logic             flag_en;

   alu_shifter #(.WIDTH(WIDTH)) u_shifter (
      .In2      (In2),
      .SR_Cont  (SR_Cont),
      .SR_Bit   (SR_Bit),
      .carry_in (Flags[FLAG_C]),
      .sh_out   (sh),
      .sh_carry (sh_carry)
   );

   // Operation select and next flag values; C and V hold unless the op defines them.
   always_comb begin
      sum    = {1'b0, In1} + {1'b0, sh};
      diff   = {1'b0, In1} - {1'b0, sh};
      result = '0;
      c_new  = Flags[FLAG_C];
      v_new  = Flags[FLAG_V];
      case (Opcode)
         OP_ADD: begin
            result = sum[WIDTH-1:0];
            c_new  = sum[WIDTH];
            v_new  = add_overflow(In1[WIDTH-1], sh[WIDTH-1], sum[WIDTH-1]);
         end
         OP_SUB: begin
            result = diff[WIDTH-1:0];
            c_new  = ~diff[WIDTH];
            v_new  = add_overflow(In1[WIDTH-1], ~sh[WIDTH-1], diff[WIDTH-1]);
         end
         OP_MUL:  result = In1 * sh;
         OP_OR: begin
            result = In1 | sh;
            c_new  = sh_carry;
         end
         OP_AND: begin
            result = In1 & sh;
            c_new  = sh_carry;
         end
         OP_XOR: begin
            result = In1 ^ sh;
            c_new  = sh_carry;
         end
         OP_MOVI: result = {{(WIDTH-IMM_WIDTH){1'b0}}, Immediate};
         OP_MOV:  result = In1;
         default: result = '0;
      endcase
      flags_next = {result[WIDTH-1], (result == '0), c_new, v_new};
      flag_en    = S && (Opcode[3] == 1'b0);
   end

   // Result register every cycle; flags only when enabled by S on a defined opcode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Out   <= '0;
         Flags <= '0;
      end else begin
         Out <= result;
         if (flag_en) Flags <= flags_next;
      end
   end

endmodule

// File: tb/tb_alu_simple.sv
// Directed-vector bench for alu_simple with hand-computed results and flags.
module tb_alu_simple;

   logic        clk;
   logic        rst;
   logic [31:0] In1;
   logic [31:0] In2;
   logic [15:0] Immediate;
   logic [3:0]  Opcode;
   logic [2:0]  SR_Cont;
   logic [4:0]  SR_Bit;
   logic        S;
   logic [31:0] Out;
   logic [3:0]  Flags;

   int n_checks;
   int n_errors;

   alu_simple dut (
      .clk       (clk),
      .rst       (rst),
      .In1       (In1),
      .In2       (In2),
      .Immediate (Immediate),
      .Opcode    (Opcode),
      .SR_Cont   (SR_Cont),
      .SR_Bit    (SR_Bit),
      .S         (S),
      .Out       (Out),
      .Flags     (Flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Drive one operation between edges, then check Out/Flags just after the edge.
   task automatic run_op(input string tag, input logic [3:0] op,
                         input logic [2:0] sc, input logic [4:0] sb,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] imm, input logic s_en,
                         input logic [31:0] exp_out, input logic [3:0] exp_flags);
      @(negedge clk);
      Opcode = op; SR_Cont = sc; SR_Bit = sb;
      In1 = a; In2 = b; Immediate = imm; S = s_en;
      @(posedge clk);
      #1;
      check_val({tag, "_out"}, Out, exp_out);
      check_val({tag, "_flags"}, {28'd0, Flags}, {28'd0, exp_flags});
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      In1 = '0; In2 = '0; Immediate = '0; Opcode = '0;
      SR_Cont = '0; SR_Bit = '0; S = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("reset_out", Out, 32'd0);
      check_val("reset_flags", {28'd0, Flags}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      //      tag         op     sc      sb    In1           In2           imm      S     Out           NZCV
      run_op("add",      4'd0, 3'b000, 5'd0, 32'd15,       32'd20,       16'd0,   1'b1, 32'd35,       4'b0000);
      run_op("sub",      4'd1, 3'b000, 5'd0, 32'd30,       32'd10,       16'd0,   1'b1, 32'd20,       4'b0010);
      run_op("or",       4'd3, 3'b000, 5'd0, 32'h0A0,      32'h005,      16'd0,   1'b1, 32'h0A5,      4'b0010);
      run_op("and",      4'd4, 3'b000, 5'd0, 32'h0F0,      32'h00F,      16'd0,   1'b1, 32'h000,      4'b0110);
      run_op("xor",      4'd5, 3'b000, 5'd0, 32'h0FF,      32'h0F0,      16'd0,   1'b1, 32'h00F,      4'b0010);
      run_op("add_wrap", 4'd0, 3'b000, 5'd0, 32'hFFFFFFFF, 32'd1,        16'd0,   1'b1, 32'd0,        4'b0110);
      run_op("sub_neg",  4'd1, 3'b000, 5'd0, 32'd10,       32'd30,       16'd0,   1'b1, 32'hFFFFFFEC, 4'b1000);
      run_op("add_ovf",  4'd0, 3'b000, 5'd0, 32'h7FFFFFFF, 32'd1,        16'd0,   1'b1, 32'h80000000, 4'b1001);
      run_op("mul",      4'd2, 3'b000, 5'd0, 32'd5,        32'd5,        16'd0,   1'b1, 32'd25,       4'b0001);
      run_op("sub_ovf",  4'd1, 3'b000, 5'd0, 32'h80000000, 32'd1,        16'd0,   1'b1, 32'h7FFFFFFF, 4'b0011);
      run_op("add_lsr",  4'd0, 3'b001, 5'd4, 32'd30,       32'd10,       16'd0,   1'b1, 32'd30,       4'b0000);
      run_op("add_lsl",  4'd0, 3'b010, 5'd4, 32'd30,       32'd10,       16'd0,   1'b1, 32'd190,      4'b0000);
      run_op("add_ror",  4'd0, 3'b011, 5'd4, 32'd30,       32'd10,       16'd0,   1'b1, 32'hA000001E, 4'b1000);
      run_op("add_asr",  4'd0, 3'b100, 5'd4, 32'd0,        32'h80000000, 16'd0,   1'b1, 32'hF8000000, 4'b1000);
      run_op("or_lsr_c", 4'd3, 3'b001, 5'd2, 32'd0,        32'h0000000A, 16'd0,   1'b1, 32'd2,        4'b0010);
      run_op("and_lsl_c",4'd4, 3'b010, 5'd1, 32'hFFFFFFFF, 32'h80000000, 16'd0,   1'b1, 32'd0,        4'b0110);
      run_op("xor_ror_c",4'd5, 3'b011, 5'd1, 32'd0,        32'd1,        16'd0,   1'b1, 32'h80000000, 4'b1010);
      run_op("sh_rsvd",  4'd0, 3'b101, 5'd3, 32'd0,        32'd5,        16'd0,   1'b1, 32'd5,        4'b0000);
      run_op("add_cvz",  4'd0, 3'b000, 5'd0, 32'h80000000, 32'h80000000, 16'd0,   1'b1, 32'd0,        4'b0111);
      run_op("movi",     4'd6, 3'b000, 5'd0, 32'd7,        32'd9,        16'd60,  1'b1, 32'd60,       4'b0011);
      run_op("mov",      4'd7, 3'b010, 5'd3, 32'd30,       32'd99,       16'd0,   1'b1, 32'd30,       4'b0011);
      run_op("xor_amt0", 4'd5, 3'b001, 5'd0, 32'd0,        32'h00000080, 16'd0,   1'b1, 32'h80,       4'b0011);
      run_op("sub_s0",   4'd1, 3'b000, 5'd0, 32'd5,        32'd5,        16'd0,   1'b0, 32'd0,        4'b0011);
      run_op("op9",      4'd9, 3'b000, 5'd0, 32'd5,        32'd5,        16'd0,   1'b1, 32'd0,        4'b0011);
      run_op("movi_zx",  4'd6, 3'b000, 5'd0, 32'd0,        32'd0,        16'hFFFF,1'b1, 32'h0000FFFF, 4'b0011);
      run_op("add_pre",  4'd0, 3'b000, 5'd0, 32'd15,       32'd20,       16'd0,   1'b1, 32'd35,       4'b0000);

      // Asynchronous reset between edges, held across two edges, then released.
      #3;
      rst = 1'b1;
      #1;
      check_val("async_rst_out", Out, 32'd0);
      check_val("async_rst_flags", {28'd0, Flags}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_hold_out", Out, 32'd0);
      check_val("rst_hold_flags", {28'd0, Flags}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      Opcode = 4'd0; SR_Cont = 3'b000; SR_Bit = 5'd0;
      In1 = 32'd1; In2 = 32'd2; S = 1'b1;
      @(posedge clk);
      #1;
      check_val("post_rst_out", Out, 32'd3);
      check_val("post_rst_flags", {28'd0, Flags}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
